daisy_chain_irq_controller: RTL and testbench

//  Central controller for the active-low daisy-chain priority interrupt chain.

---
 rtl/daisy_chain_irq_controller.sv | 149 ++++++++++++++
 tb/tb_daisy_chain_irq_controller.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daisy_chain_irq_controller.sv
// Central controller for an active-low daisy-chain priority interrupt string.
// Synchronises the wired-OR chain request, raises the CPU interrupt, drives the
// chain-head ACK on INTA, resolves the granting tap into a vector and holds
// in-service until the CPU signals end-of-interrupt.
module daisy_chain_irq_controller #(
   parameter int               N_DEV       = 4,
   parameter int               VEC_W       = 8,
   parameter logic [VEC_W-1:0] VEC_BASE    = 'h40,
   parameter int               ACK_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             irq_n_chain,
   input  logic [N_DEV-1:0] ack_k_n,
   output logic             ack_n_chain,
   input  logic             en,
   output logic             int_n,
   input  logic             inta,
   input  logic             eoi,
   output logic [VEC_W-1:0] vector,
   output logic             vec_valid,
   output logic             in_service,
   output logic             spurious
);

   localparam int CNT_W = $clog2(ACK_TIMEOUT + 1);
   localparam int IDX_W = (N_DEV > 1) ? $clog2(N_DEV) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PEND    = 2'd1,
      ST_ACK     = 2'd2,
      ST_SERVICE = 2'd3
   } state_t;

   state_t           state;
   state_t           state_next;
   logic             sync1;
   logic             sync2;
   logic             irq_s;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             tap_hit;
   logic [IDX_W-1:0] tap_idx;
   logic [VEC_W-1:0] vector_next;
   logic             vec_valid_next;
   logic             spurious_next;

   // Two-flop synchroniser for the asynchronous chain request; resets to the deasserted level
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= irq_n_chain;
         sync2 <= sync1;
      end
   end

   assign irq_s = ~sync2;

   // Find the lowest-index tap pulled low; the tap nearest the chain head has priority
   always_comb begin
      tap_hit = ~&ack_k_n;
      tap_idx = '0;
      for (int i = N_DEV - 1; i >= 0; i--) begin
         if (!ack_k_n[i]) begin
            tap_idx = IDX_W'(i);
         end
      end
   end

   // State and ACK-timeout counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // Next-state, counter and pulse/vector decisions; a tap low on the timeout edge beats the timeout
   always_comb begin
      state_next     = state;
      cnt_next       = cnt;
      vector_next    = vector;
      vec_valid_next = 1'b0;
      spurious_next  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (irq_s && en) begin
               state_next = ST_PEND;
            end
         end
         ST_PEND: begin
            if (inta) begin
               state_next = ST_ACK;
               cnt_next   = '0;
            end
         end
         ST_ACK: begin
            if (tap_hit) begin
               vector_next    = VEC_BASE + VEC_W'(tap_idx);
               vec_valid_next = 1'b1;
               state_next     = ST_SERVICE;
            end else if (cnt == CNT_LAST - CNT_W'(1)) begin
               cnt_next       = CNT_LAST;
               vector_next    = '1;
               vec_valid_next = 1'b1;
               spurious_next  = 1'b1;
               state_next     = ST_IDLE;
            end else if (cnt != CNT_LAST) begin
               cnt_next = cnt + CNT_W'(1);
            end
         end
         ST_SERVICE: begin
            if (eoi) begin
               state_next = ST_IDLE;
            end
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
   end

   // Registered outputs, decoded from the state being entered so they change on the same edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_n_chain <= 1'b1;
         int_n       <= 1'b1;
         vector      <= '0;
         vec_valid   <= 1'b0;
         in_service  <= 1'b0;
         spurious    <= 1'b0;
      end else begin
         ack_n_chain <= (state_next != ST_ACK);
         int_n       <= !((state_next == ST_PEND) || (state_next == ST_ACK));
         vector      <= vector_next;
         vec_valid   <= vec_valid_next;
         in_service  <= (state_next == ST_SERVICE);
         spurious    <= spurious_next;
      end
   end

endmodule

// File: tb/tb_daisy_chain_irq_controller.sv
// Self-checking bench for daisy_chain_irq_controller: directed scenarios with
// literal expectations, then randomized traffic checked every cycle against a
// behavioural model of the controller.
module tb_daisy_chain_irq_controller;

   localparam int         N_DEV   = 4;
   localparam int         VEC_W   = 8;
   localparam logic [7:0] BASE    = 8'h40;
   localparam int         TIMEOUT = 15;

   localparam int M_IDLE = 0;
   localparam int M_PEND = 1;
   localparam int M_ACK  = 2;
   localparam int M_SVC  = 3;

   logic             clk = 1'b0;
   logic             rst_n = 1'b1;
   logic             irq_n_chain = 1'b1;
   logic [N_DEV-1:0] ack_k_n = '1;
   logic             en = 1'b0;
   logic             inta = 1'b0;
   logic             eoi = 1'b0;
   logic             ack_n_chain;
   logic             int_n;
   logic [VEC_W-1:0] vector;
   logic             vec_valid;
   logic             in_service;
   logic             spurious;

   int n_vec  = 0;
   int n_miss = 0;
   bit chk_on = 1'b0;

   // Model state: what the controller is doing, plus history of sampled irq levels
   int         m_mode;
   logic       m_h1;
   logic       m_h2;
   int         m_waited;
   logic [7:0] m_vec;
   logic       m_vv;
   logic       m_sp;

   daisy_chain_irq_controller #(
      .N_DEV(N_DEV),
      .VEC_W(VEC_W),
      .VEC_BASE(BASE),
      .ACK_TIMEOUT(TIMEOUT)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .irq_n_chain(irq_n_chain),
      .ack_k_n(ack_k_n),
      .ack_n_chain(ack_n_chain),
      .en(en),
      .int_n(int_n),
      .inta(inta),
      .eoi(eoi),
      .vector(vector),
      .vec_valid(vec_valid),
      .in_service(in_service),
      .spurious(spurious)
   );

   // Free-running clock, period 10
   always #5 clk = ~clk;

   // Behavioural model: request seen two samples late, lowest low tap wins, timeout after TIMEOUT empty ACK cycles
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_mode   = M_IDLE;
         m_h1     = 1'b1;
         m_h2     = 1'b1;
         m_waited = 0;
         m_vec    = 8'h00;
         m_vv     = 1'b0;
         m_sp     = 1'b0;
      end else begin
         bit req;
         int low;
         req  = (m_h2 == 1'b0);
         m_h2 = m_h1;
         m_h1 = irq_n_chain;
         m_vv = 1'b0;
         m_sp = 1'b0;
         case (m_mode)
            M_IDLE: if (req && en) m_mode = M_PEND;
            M_PEND: if (inta) begin
               m_mode   = M_ACK;
               m_waited = 0;
            end
            M_ACK: begin
               low = -1;
               for (int i = N_DEV - 1; i >= 0; i--) begin
                  if (ack_k_n[i] == 1'b0) low = i;
               end
               if (low >= 0) begin
                  m_vec  = BASE + 8'(low);
                  m_vv   = 1'b1;
                  m_mode = M_SVC;
               end else begin
                  m_waited++;
                  if (m_waited == TIMEOUT) begin
                     m_vec  = 8'hFF;
                     m_vv   = 1'b1;
                     m_sp   = 1'b1;
                     m_mode = M_IDLE;
                  end
               end
            end
            M_SVC: if (eoi) m_mode = M_IDLE;
            default: m_mode = M_IDLE;
         endcase
      end
   end

   task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs at the falling edge and advance to the next falling edge
   task automatic applyStimulus(input logic irq, input logic e, input logic ia, input logic eo,
                                input logic [N_DEV-1:0] taps);
      irq_n_chain = irq;
      en          = e;
      inta        = ia;
      eoi         = eo;
      ack_k_n     = taps;
      @(negedge clk);
   endtask

   task automatic waitIntLow(input string name);
      for (int k = 0; k < 8 && int_n !== 1'b0; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      end
      checkOutput(name, int_n, 8'd0);
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_ack_n"}, ack_n_chain, 8'd1);
      checkOutput({tag, "_int_n"}, int_n, 8'd1);
      checkOutput({tag, "_vector"}, vector, 8'h00);
      checkOutput({tag, "_vec_valid"}, vec_valid, 8'd0);
      checkOutput({tag, "_in_service"}, in_service, 8'd0);
      checkOutput({tag, "_spurious"}, spurious, 8'd0);
   endtask

   // Cycle-by-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (chk_on) begin
         checkOutput("model_int_n", int_n, (m_mode == M_PEND || m_mode == M_ACK) ? 8'd0 : 8'd1);
         checkOutput("model_ack_n", ack_n_chain, (m_mode == M_ACK) ? 8'd0 : 8'd1);
         checkOutput("model_in_service", in_service, (m_mode == M_SVC) ? 8'd1 : 8'd0);
         checkOutput("model_vector", vector, m_vec);
         checkOutput("model_vec_valid", vec_valid, {7'd0, m_vv});
         checkOutput("model_spurious", spurious, {7'd0, m_sp});
      end
   end

   // Watchdog so the run always ends
   initial begin
      #400000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      chk_on = 1'b1;
      checkResetValues("reset");
      rst_n = 1'b1;

      // Single request: latency, tap 2 -> 0x42, EOI
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t1_int_n_E", int_n, 8'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t1_int_n_E1", int_n, 8'd1);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t1_int_n_E2", int_n, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      checkOutput("t1_ack_n", ack_n_chain, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1011);
      checkOutput("t1_vector", vector, 8'h42);
      checkOutput("t1_vec_valid", vec_valid, 8'd1);
      checkOutput("t1_in_service", in_service, 8'd1);
      checkOutput("t1_ack_released", ack_n_chain, 8'd1);
      checkOutput("t1_int_released", int_n, 8'd1);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t1_vec_valid_pulse", vec_valid, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
      checkOutput("t1_eoi", in_service, 8'd0);

      // Priority: two taps low, lowest index wins
      waitIntLow("t2_reach_pend");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b1001);
      checkOutput("t2_vector", vector, 8'h41);
      checkOutput("t2_spurious", spurious, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF);

      // Timeout: no tap ever answers
      waitIntLow("t3_reach_pend");
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      repeat (14) applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t3_still_ack", ack_n_chain, 8'd0);
      checkOutput("t3_no_valid_yet", vec_valid, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t3_vector", vector, 8'hFF);
      checkOutput("t3_vec_valid", vec_valid, 8'd1);
      checkOutput("t3_spurious", spurious, 8'd1);
      checkOutput("t3_int_n", int_n, 8'd1);
      checkOutput("t3_ack_n", ack_n_chain, 8'd1);
      checkOutput("t3_in_service", in_service, 8'd0);

      // Masking and hold
      for (int k = 0; k < 20; k++) begin
         applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'hF);
         checkOutput("t4_masked", int_n, 8'd1);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t4_unmasked", int_n, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 4'hF);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b1110);
      checkOutput("t4_vector", vector, 8'h40);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
         checkOutput("t4_held", int_n, 8'd1);
      end
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'hF);
      checkOutput("t4_eoi_int_n", int_n, 8'd1);
      checkOutput("t4_eoi_in_service", in_service, 8'd0);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t4_reasserted", int_n, 8'd0);

      // Reset in the middle of ACK, away from any clock edge
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      checkOutput("t5_in_ack", ack_n_chain, 8'd0);
      #2 rst_n = 1'b0;
      #1 checkResetValues("t5_async");
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'hF);
      checkOutput("t5_idle_int_n", int_n, 8'd1);
      checkOutput("t5_idle_ack_n", ack_n_chain, 8'd1);

      // Stray inputs
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      checkOutput("t6_idle_int_n", int_n, 8'd1);
      checkOutput("t6_idle_ack_n", ack_n_chain, 8'd1);
      checkOutput("t6_idle_in_service", in_service, 8'd0);
      checkOutput("t6_idle_vector", vector, 8'h00);
      waitIntLow("t6_reach_pend");
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'hF);
      checkOutput("t6_pend_int_n", int_n, 8'd0);
      checkOutput("t6_pend_ack_n", ack_n_chain, 8'd1);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'b0111);
      checkOutput("t6_vector", vector, 8'h43);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'hF);
      checkOutput("t6_svc_in_service", in_service, 8'd1);
      checkOutput("t6_svc_vec_valid", vec_valid, 8'd0);
      applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'hF);
      checkOutput("t6_svc_inta_eoi", in_service, 8'd0);

      // Randomized traffic, with occasional asynchronous reset pulses
      for (int n = 0; n < 3000; n++) begin
         logic             r_irq;
         logic             r_en;
         logic             r_inta;
         logic             r_eoi;
         logic [N_DEV-1:0] r_taps;
         r_irq  = 1'($urandom_range(0, 1));
         r_en   = ($urandom_range(0, 7) != 0);
         r_inta = ($urandom_range(0, 3) == 0);
         r_eoi  = ($urandom_range(0, 5) == 0);
         r_taps = ($urandom_range(0, 9) != 0) ? 4'hF : 4'($urandom_range(0, 15));
         if ($urandom_range(0, 499) == 0) begin
            #3 rst_n = 1'b0;
            #1 rst_n = 1'b1;
         end
         applyStimulus(r_irq, r_en, r_inta, r_eoi, r_taps);
      end

      chk_on = 1'b0;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
